// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Register file for the RISCVX core with a per-register busy scoreboard.
// - Two combinational read ports, one write-back port.
// - Optional write-to-read bypass (BYPASS) and optional hardwired x0 (ZERO_REG).
// - The storage array has no reset. After reset it is cleared one register per
//   cycle, so it can map onto LUTRAM. The block is not ready during that time.
//
// Parameters
//   XLEN      data width of each register
//   AW        address width, NREGS = 2**AW
//   ZERO_REG  1: reg 0 reads 0, is never written and is never busy
//   BYPASS    1: same-cycle write-back data is forwarded to the read ports
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous reset, active-high
//   ready     1 once the post-reset clear has finished
//   rs1_addr  read port 1 address
//   rs1_data  read port 1 data
//   rs1_busy  read port 1 register has a write pending
//   rs2_addr  read port 2 address
//   rs2_data  read port 2 data
//   rs2_busy  read port 2 register has a write pending
//   issue_vld an instruction writing issue_rd issues this cycle
//   issue_rd  destination register of the issued instruction
//   wb_vld    write-back valid
//   wb_rd     write-back register address
//   wb_data   write-back data
//   flush     clear every busy bit
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_busy,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_busy,
    input  logic            issue_vld,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb_vld,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush
);

    localparam int NREGS = 1 << AW;
    localparam logic [AW-1:0] LAST_REG  = AW'(NREGS - 1);
    localparam logic [AW-1:0] FIRST_REG = AW'(ZERO_REG);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     clr_cnt;
    logic [AW-1:0]     clr_cnt_nxt;
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic [XLEN-1:0]   regs [NREGS];

    logic              run;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [XLEN-1:0]   wdata;
    logic              wb_ok;
    logic              hit1;
    logic              hit2;
    logic              zero1;
    logic              zero2;

    assign run   = (state == S_RUN);
    assign ready = run;

    // A write-back to x0 is dropped when x0 is hardwired.
    assign wb_ok = wb_vld && !((ZERO_REG != 0) && (wb_rd == '0));

    // ------------------------------------------------------------------
    // Control state: FSM, clear counter, busy scoreboard
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_INIT;
            clr_cnt <= FIRST_REG;
            busy    <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            busy    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            S_INIT: begin
                // The counter stops at the last register instead of wrapping.
                if (clr_cnt == LAST_REG) begin
                    state_nxt = S_RUN;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            S_RUN: begin
                state_nxt = S_RUN;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Flush beats everything. Issue is applied after write-back so that a
    // younger writer to the same register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (run) begin
            if (flush) begin
                busy_nxt = '0;
            end else begin
                if (wb_vld) begin
                    busy_nxt[wb_rd] = 1'b0;
                end
                if (issue_vld) begin
                    busy_nxt[issue_rd] = 1'b1;
                end
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Storage array (no reset): INIT clear or RUN write-back
    // ------------------------------------------------------------------
    always_comb begin
        we    = 1'b0;
        waddr = wb_rd;
        wdata = wb_data;
        if (!run) begin
            we    = 1'b1;
            waddr = clr_cnt;
            wdata = '0;
        end else if (wb_ok) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) begin
            regs[waddr] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    assign hit1  = (BYPASS != 0) && wb_vld && (wb_rd == rs1_addr);
    assign hit2  = (BYPASS != 0) && wb_vld && (wb_rd == rs2_addr);
    assign zero1 = (ZERO_REG != 0) && (rs1_addr == '0);
    assign zero2 = (ZERO_REG != 0) && (rs2_addr == '0);

    always_comb begin
        rs1_data = '0;
        if (run && !zero1) begin
            rs1_data = hit1 ? wb_data : regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (run && !zero2) begin
            rs2_data = hit2 ? wb_data : regs[rs2_addr];
        end
    end

    // A bypassed write-back satisfies the pending write in the same cycle.
    assign rs1_busy = run && busy[rs1_addr] && !hit1;
    assign rs2_busy = run && busy[rs2_addr] && !hit2;

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Self-checking bench for reg_file_sb at default parameters
// (XLEN=32, AW=5, ZERO_REG=1, BYPASS=1).
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic        ready;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic        rs1_busy;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic        rs2_busy;
    logic        issue_vld;
    logic [4:0]  issue_rd;
    logic        wb_vld;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;

    int n_chk;
    int n_fail;

    reg_file_sb #(
        .XLEN(32), .AW(5), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
        .issue_vld(issue_vld), .issue_rd(issue_rd),
        .wb_vld(wb_vld), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        isv;
        logic [4:0]  isrd;
        logic        fl;
        logic [31:0] e1d;
        logic [31:0] e2d;
        logic        e1b;
        logic        e2b;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
        input logic isv, input logic [4:0] isrd, input logic fl,
        input logic [31:0] e1d, input logic [31:0] e2d,
        input logic e1b, input logic e2b);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
        v.isv = isv; v.isrd = isrd; v.fl = fl;
        v.e1d = e1d; v.e2d = e2d; v.e1b = e1b; v.e2b = e2b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic idle_inputs();
        issue_vld = 1'b0; issue_rd = '0;
        wb_vld = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0;
    endtask

    // Counts rising edges until ready, bounded; returns the count or -1.
    task automatic count_to_ready(output int cnt);
        cnt = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        int cnt;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        idle_inputs();

        // Reset and post-reset clear
        #12;
        chk("ready_in_reset", {31'd0, ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("ready_after_release", {31'd0, ready}, 32'd0);
        count_to_ready(cnt);
        chk("init_cycles", cnt, 32'd31);

        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #0.1;
            chk($sformatf("clr_rs1_data[%0d]", a), rs1_data, 32'd0);
            chk($sformatf("clr_rs2_busy[%0d]", 31 - a), {31'd0, rs2_busy}, 32'd0);
        end
        @(posedge clk); #1;

        // Directed RUN vectors
        //             rs1 rs2 wbv wbrd wbd            isv isrd fl  e1d            e2d            e1b  e2b
        vecs[0]  = mk(5,  5,  1, 5,  32'hDEADBEEF, 0, 0,  0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vecs[1]  = mk(5,  0,  0, 0,  32'h0,        0, 0,  0, 32'hDEADBEEF, 32'h0,        0, 0);
        vecs[2]  = mk(0,  0,  1, 0,  32'h1234,     0, 0,  0, 32'h0,        32'h0,        0, 0);
        vecs[3]  = mk(1,  0,  0, 0,  32'h0,        1, 0,  0, 32'h0,        32'h0,        0, 0);
        vecs[4]  = mk(0,  0,  0, 0,  32'h0,        0, 0,  0, 32'h0,        32'h0,        0, 0);
        vecs[5]  = mk(7,  0,  0, 0,  32'h0,        1, 7,  0, 32'h0,        32'h0,        0, 0);
        vecs[6]  = mk(7,  5,  0, 0,  32'h0,        0, 0,  0, 32'h0,        32'hDEADBEEF, 1, 0);
        vecs[7]  = mk(7,  7,  1, 7,  32'h77,       1, 7,  0, 32'h77,       32'h77,       0, 0);
        vecs[8]  = mk(7,  8,  0, 0,  32'h0,        0, 0,  0, 32'h77,       32'h0,        1, 0);
        vecs[9]  = mk(7,  0,  1, 7,  32'h88,       0, 0,  0, 32'h88,       32'h0,        0, 0);
        vecs[10] = mk(7,  0,  0, 0,  32'h0,        0, 0,  0, 32'h88,       32'h0,        0, 0);
        vecs[11] = mk(3,  0,  0, 0,  32'h0,        1, 3,  0, 32'h0,        32'h0,        0, 0);
        vecs[12] = mk(3,  0,  0, 0,  32'h0,        1, 9,  0, 32'h0,        32'h0,        1, 0);
        vecs[13] = mk(9,  3,  0, 0,  32'h0,        1, 31, 0, 32'h0,        32'h0,        1, 1);
        vecs[14] = mk(31, 9,  0, 0,  32'h0,        1, 4,  1, 32'h0,        32'h0,        1, 1);
        vecs[15] = mk(3,  4,  0, 0,  32'h0,        0, 0,  0, 32'h0,        32'h0,        0, 0);
        vecs[16] = mk(9,  31, 0, 0,  32'h0,        0, 0,  0, 32'h0,        32'h0,        0, 0);
        vecs[17] = mk(31, 30, 1, 31, 32'hA5A5A5A5, 0, 0,  0, 32'hA5A5A5A5, 32'h0,        0, 0);
        vecs[18] = mk(31, 30, 0, 0,  32'h0,        0, 0,  0, 32'hA5A5A5A5, 32'h0,        0, 0);
        vecs[19] = mk(20, 5,  1, 20, 32'hFFFFFFFF, 0, 0,  0, 32'hFFFFFFFF, 32'hDEADBEEF, 0, 0);
        vecs[20] = mk(5,  20, 0, 0,  32'h0,        0, 0,  0, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0);
        vecs[21] = mk(6,  0,  1, 6,  32'h66,       0, 0,  1, 32'h66,       32'h0,        0, 0);
        vecs[22] = mk(6,  20, 0, 0,  32'h0,        0, 0,  0, 32'h66,       32'hFFFFFFFF, 0, 0);

        for (int i = 0; i < NV; i++) begin
            rs1_addr  = vecs[i].rs1;
            rs2_addr  = vecs[i].rs2;
            wb_vld    = vecs[i].wbv;
            wb_rd     = vecs[i].wbrd;
            wb_data   = vecs[i].wbd;
            issue_vld = vecs[i].isv;
            issue_rd  = vecs[i].isrd;
            flush     = vecs[i].fl;
            #4;
            chk($sformatf("v%0d rs1_data", i), rs1_data, vecs[i].e1d);
            chk($sformatf("v%0d rs2_data", i), rs2_data, vecs[i].e2d);
            chk($sformatf("v%0d rs1_busy", i), {31'd0, rs1_busy}, {31'd0, vecs[i].e1b});
            chk($sformatf("v%0d rs2_busy", i), {31'd0, rs2_busy}, {31'd0, vecs[i].e2b});
            @(posedge clk); #1;
        end

        // Reset clears busy asynchronously
        idle_inputs();
        issue_vld = 1'b1; issue_rd = 5'd12;
        @(posedge clk); #1;
        idle_inputs();
        rs2_addr = 5'd12;
        #1;
        chk("busy12_set", {31'd0, rs2_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ready_async_rst", {31'd0, ready}, 32'd0);
        chk("busy12_async_rst", {31'd0, rs2_busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // INIT ignores write-back and issue; rst mid-INIT restarts the clear
        wb_vld = 1'b1; wb_rd = 5'd20; wb_data = 32'h1111;
        issue_vld = 1'b1; issue_rd = 5'd13;
        rs1_addr = 5'd20;
        rs2_addr = 5'd13;
        repeat (10) @(posedge clk);
        #1;
        chk("init10_ready", {31'd0, ready}, 32'd0);
        chk("init10_rs1_data", rs1_data, 32'd0);
        chk("init10_rs2_busy", {31'd0, rs2_busy}, 32'd0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        count_to_ready(cnt);
        chk("reinit_cycles", cnt, 32'd31);
        idle_inputs();
        #1;
        chk("reinit_reg20", rs1_data, 32'd0);
        chk("reinit_busy13", {31'd0, rs2_busy}, 32'd0);
        rs1_addr = 5'd5;
        rs2_addr = 5'd12;
        #1;
        chk("reinit_reg5", rs1_data, 32'd0);
        chk("reinit_busy12", {31'd0, rs2_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
